csr_timer_bank: RTL

Parametrised multi-channel timer and interrupt-source block for the CSR unit. It replaces the single fixed TCFG/TVAL/TICLR timer with NUM_TIMERS independent channels of configurable width, each in one-shot or periodic mode, with a global freeze. It also provides 2-flop synchronisation of external hardware interrupt lines. Outputs feed the ESTAT.IS pending bits (timer on IS[11], HWI on IS[9:2]) and csrrd/csrwr/csrxchg read/write data.

---
 rtl/csr_timer_bank_pkg.sv | 31 +++
 rtl/csr_timer_bank_if.sv | 30 +++
 rtl/csr_timer_bank_channel.sv | 61 ++++++
 rtl/csr_timer_bank.sv | 138 +++++++++++++
 4 files changed

// File: rtl/csr_timer_bank_pkg.sv
// Shared types and constants for the CSR timer bank: write-target encoding,
// TCFG field layout and the channel-select width helper.
package csr_timer_bank_pkg;

    // Write-side target encoding; slot 3 is reserved on writes because TVAL is read-only.
    typedef enum logic [1:0] {
        TCFG_S  = 2'd0,
        TICLR_S = 2'd1,
        TID_S   = 2'd2,
        TVAL_S  = 2'd3
    } timer_sel_e;

    localparam logic [1:0] RSEL_TCFG  = 2'd0;
    localparam logic [1:0] RSEL_TVAL  = 2'd1;
    localparam logic [1:0] RSEL_TICLR = 2'd2;
    localparam logic [1:0] RSEL_TID   = 2'd3;

    localparam int TCFG_EN_BIT  = 0;
    localparam int TCFG_PER_BIT = 1;

    typedef struct packed {
        logic [29:0] initval;
        logic        periodic;
        logic        en;
    } timer_cfg_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csr_timer_bank_if.sv
// CSR access bus for the timer bank: single-cycle write strobe with optional
// xchg mask, plus a combinational read port.
interface csr_timer_bank_if
    import csr_timer_bank_pkg::*;
#(
    parameter int NUM_TIMERS = 1,
    parameter int CH_W       = ch_width(NUM_TIMERS)
);
    logic            csr_we;
    logic [1:0]      csr_wsel;
    logic [CH_W-1:0] csr_wch;
    logic [31:0]     csr_wdata;
    logic [31:0]     csr_wmask;
    logic            csr_me;
    logic [1:0]      csr_rsel;
    logic [CH_W-1:0] csr_rch;
    logic [31:0]     csr_rdata;

    modport master (
        output csr_we, csr_wsel, csr_wch, csr_wdata, csr_wmask, csr_me,
        output csr_rsel, csr_rch,
        input  csr_rdata
    );

    modport slave (
        input  csr_we, csr_wsel, csr_wch, csr_wdata, csr_wmask, csr_me,
        input  csr_rsel, csr_rch,
        output csr_rdata
    );
endinterface

// File: rtl/csr_timer_bank_channel.sv
// One timer channel: TCFG register, down-counting TVAL and the sticky
// interrupt-pending flag.
module csr_timer_bank_channel
    import csr_timer_bank_pkg::*;
#(
    parameter int TIMER_WIDTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        freeze,
    input  logic        cfg_we,
    input  logic [31:0] cfg_wdata,
    input  logic        clr,
    output logic [31:0] cfg_rd,
    output logic [31:0] tval_rd,
    output logic        pending
);
    localparam logic [31:0] WIDTH_MASK = 32'((33'h1 << TIMER_WIDTH) - 33'h1);

    timer_cfg_t             cfg_q;
    timer_cfg_t             cfg_new;
    logic [TIMER_WIDTH-1:0] tval_q;
    logic [TIMER_WIDTH-1:0] reload;
    logic                   run;
    logic                   expire;

    assign cfg_new = timer_cfg_t'(cfg_wdata & WIDTH_MASK);
    assign reload  = TIMER_WIDTH'({cfg_q.initval, 2'b00});
    assign run     = cfg_q.en && !freeze;
    assign expire  = run && (tval_q == TIMER_WIDTH'(1));

    assign cfg_rd  = cfg_q;
    assign tval_rd = 32'(tval_q);

    // A config write always reloads TVAL; an expiry on the same edge still raises pending,
    // and expiry beats a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_q   <= '0;
            tval_q  <= '0;
            pending <= 1'b0;
        end else begin
            if (cfg_we) begin
                cfg_q  <= cfg_new;
                tval_q <= TIMER_WIDTH'({cfg_new.initval, 2'b00});
            end else if (run) begin
                if (tval_q != '0) begin
                    tval_q <= tval_q - TIMER_WIDTH'(1);
                end else if (cfg_q.periodic) begin
                    tval_q <= reload;
                end
            end
            if (expire) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/csr_timer_bank.sv
// Multi-channel CSR timer bank with TID register and 2-flop HWI synchroniser.
// Optional STABLE_COUNTER_EN adds a free-running 64-bit stable counter.
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int NUM_TIMERS  = 1,
    parameter int TIMER_WIDTH = 32,
    parameter int NUM_HWI     = 8,
    parameter int CH_W        = ch_width(NUM_TIMERS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  freeze,
    csr_timer_bank_if.slave       bus,
    input  logic [NUM_HWI-1:0]    hwi_in,
    output logic [NUM_HWI-1:0]    hwi_sync,
    output logic [NUM_TIMERS-1:0] ti_pending,
    output logic                  timer_irq
`ifdef STABLE_COUNTER_EN
    ,
    output logic [31:0]           stable_cnt_lo,
    output logic [31:0]           stable_cnt_hi
`endif
);
    timer_sel_e            wsel;
    logic [31:0]           old_val;
    logic [31:0]           eff_wdata;
    logic [NUM_TIMERS-1:0] cfg_we;
    logic [NUM_TIMERS-1:0] clr;
    logic                  tid_we;
    logic [31:0]           tid_q;
    logic [NUM_HWI-1:0]    hwi_meta;
    logic [31:0]           cfg_rd  [NUM_TIMERS];
    logic [31:0]           tval_rd [NUM_TIMERS];

    assign wsel      = timer_sel_e'(bus.csr_wsel);
    assign timer_irq = |ti_pending;

    // Merge write data with the current register value for csrxchg, then steer the strobe.
    // Out-of-range channel indices match no channel, so those writes fall away.
    always_comb begin
        old_val = '0;
        cfg_we  = '0;
        clr     = '0;
        tid_we  = 1'b0;
        if (wsel == TCFG_S) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (bus.csr_wch == CH_W'(i)) old_val = cfg_rd[i];
            end
        end else if (wsel == TID_S) begin
            old_val = tid_q;
        end
        eff_wdata = bus.csr_me ? ((bus.csr_wdata & bus.csr_wmask) | (old_val & ~bus.csr_wmask))
                               : bus.csr_wdata;
        if (bus.csr_we) begin
            case (wsel)
                TCFG_S: begin
                    for (int i = 0; i < NUM_TIMERS; i++) begin
                        if (bus.csr_wch == CH_W'(i)) cfg_we[i] = 1'b1;
                    end
                end
                TICLR_S: begin
                    for (int i = 0; i < NUM_TIMERS; i++) begin
                        if (bus.csr_wch == CH_W'(i)) clr[i] = eff_wdata[0];
                    end
                end
                TID_S:   tid_we = 1'b1;
                default: ;
            endcase
        end
    end

    // TID ignores the channel index; TICLR always reads back zero.
    always_comb begin
        bus.csr_rdata = '0;
        if (bus.csr_rsel == RSEL_TID) begin
            bus.csr_rdata = tid_q;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (bus.csr_rch == CH_W'(i)) begin
                    if (bus.csr_rsel == RSEL_TCFG) bus.csr_rdata = cfg_rd[i];
                    if (bus.csr_rsel == RSEL_TVAL) bus.csr_rdata = tval_rd[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
        csr_timer_bank_channel #(
            .TIMER_WIDTH(TIMER_WIDTH)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .freeze   (freeze),
            .cfg_we   (cfg_we[g]),
            .cfg_wdata(eff_wdata),
            .clr      (clr[g]),
            .cfg_rd   (cfg_rd[g]),
            .tval_rd  (tval_rd[g]),
            .pending  (ti_pending[g])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q <= '0;
        end else if (tid_we) begin
            tid_q <= eff_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hwi_meta <= '0;
            hwi_sync <= '0;
        end else begin
            hwi_meta <= hwi_in;
            hwi_sync <= hwi_meta;
        end
    end

`ifdef STABLE_COUNTER_EN
    logic [63:0] stable_q;

    // Free-running regardless of freeze so software time keeps advancing while halted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_q + 64'd1;
        end
    end

    assign stable_cnt_lo = stable_q[31:0];
    assign stable_cnt_hi = stable_q[63:32];
`endif

endmodule
